alnsft_pipe: RTL and testbench
==============================

Name: alnsft_pipe

Overview:
- Parametrised, pipelined successor to the 4-lane alignment shifter in the FMA datapath.
- Right-shifts LANES accumulator words by per-lane amounts to align them to the adder input, with one guard bit and an optional sticky bit.
- Sits between exponent-compare and the add stage.
- Adds a valid/ready handshake with backpressure, a configurable pipeline depth and a per-transaction lane-enable mask.

Parameters:
- LANES, 4, number of independent shift lanes.
- W, 48, accumulator width per lane.
- SW, 6, shift-amount width per lane.
- STAGES, 2, pipeline stages (1..3); the shift bits are split across stages, LSB group first.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- lane_en  input  LANES  per-lane enable for this request.
- acc  input  LANES*W  accumulator words, lane i at [i*W +: W].
- sft  input  LANES*SW  right-shift amounts, lane i at [i*SW +: SW].
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- aln  output  LANES*(W+1)  aligned words, lane i at [i*(W+1) +: W+1].
- sticky  output  LANES  OR of bits shifted out below the guard bit (see Optional Feature).

Behaviour:
- Per-lane function: aln_i = {acc_i, 1'b0} >> sft_i, computed at W+1 bits.
  - If sft_i >= W+1, then aln_i = 0.
  - A lane with lane_en_i = 0 produces aln_i = 0 and sticky_i = 0, and its stage registers hold their value (no toggle).
- Pipeline structure:
  - STAGES register slices, each with its own valid bit v[k].
  - Stage k applies the shift sub-amount sft bits [k*ceil(SW/STAGES) +: ceil(SW/STAGES)], shifted left by that bit offset. The remaining sft bits and lane_en travel with the data.
  - Partial sticky is ORed forward stage by stage.
- Handshake:
  - A transfer occurs on any edge where valid && ready.
  - Stage k advances when v[k] = 0 or stage k+1 advances; the last stage advances when out_valid = 0 or out_ready = 1.
  - in_ready = stage-0 advance condition.
  - out_valid = v[STAGES-1]; aln and sticky come directly from the last-stage registers.
- Latency and throughput:
  - Latency is exactly STAGES cycles from acceptance to out_valid when there is no backpressure.
  - Throughput is 1 request per cycle.
  - Order is preserved, with no loss or duplication.
- Full: with all v[k] = 1 and out_ready = 0, in_ready = 0 and all stage registers hold.
- Simultaneous events: when the pipe is full and out_ready = 1 in the same cycle as in_valid = 1, the output pops and the input pushes in that same cycle (no bubble).
- Stability: while out_valid = 1 && out_ready = 0, aln and sticky are stable.
- Reset:
  - reset = 0 asynchronously clears all v[k] and all data registers to 0, giving out_valid = 0, aln = 0 and sticky = 0.
  - in_ready = 1 from the first edge after release.
  - In-flight requests are discarded on reset mid-operation.
- in_valid and the data inputs are don't-care when in_valid = 0.

Optional Feature:
- Macro: ALNSFT_STICKY_EN.
- Defined: sticky_i = OR of all bits of {acc_i, 1'b0} shifted out below bit 0, including the whole word when sft_i >= W+1. Sticky registers exist in every stage.
- Undefined: no sticky logic or registers; the sticky port is tied to 0.

Decomposition:
- Shared package fma_pkg holds:
  - default constants ALN_LANES = 4, ALN_W = 48, ALN_SW = 6;
  - sftit/sftot struct typedefs sized from those constants, for wrapper binding.
- One sub-module, alnsft_lane: a single lane with STAGES staged shift slices plus sticky, controlled by the shared stage-enable vector from the top.
- The top instantiates LANES copies in a generate loop and owns the valid/ready control.

Test Plan:
Defaults apply: LANES = 4, W = 48, SW = 6, STAGES = 2.
1. acc0 = 48'h8000_0000_0000, sft0 = 0, lane_en = 4'b0001 -> after 2 cycles, aln0 = 49'h1_0000_0000_0000, sticky0 = 0, aln1..3 = 0.
2. acc1 = 1 with sft1 = 1 -> aln1 = 1, sticky1 = 0. Next request, acc1 = 1 with sft1 = 2 -> aln1 = 0, sticky1 = 1 (STICKY_EN).
3. acc2 = 48'hFFFF_FFFF_FFFF, sft2 = 63 -> aln2 = 0, sticky2 = 1. Same with acc2 = 0 -> sticky2 = 0.
4. Stream 6 back-to-back requests with out_ready held 0 -> in_ready falls after 2 accepts. Raise out_ready -> results emerge in order, 1 per cycle, no loss.
5. Pipe full, in_valid = 1 and out_ready = 1 in the same cycle -> one pop and one push that cycle; in_ready stays 1.
6. Assert reset = 0 mid-stream with 2 requests in flight -> out_valid, aln and sticky go to 0 immediately. After release, the first new request appears 2 cycles after acceptance.

Source files
------------

// File: rtl/fma_pkg.sv
// Shared FMA datapath constants and wrapper-binding types for the alignment shifter.
package fma_pkg;

    localparam int ALN_LANES = 4;
    localparam int ALN_W     = 48;
    localparam int ALN_SW    = 6;

    typedef struct packed {
        logic [ALN_LANES-1:0]        lane_en;
        logic [ALN_LANES*ALN_SW-1:0] sft;
        logic [ALN_LANES*ALN_W-1:0]  acc;
    } sftit;

    typedef struct packed {
        logic [ALN_LANES-1:0]           sticky;
        logic [ALN_LANES*(ALN_W+1)-1:0] aln;
    } sftot;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/alnsft_lane.sv
// One alignment lane: STAGES staged right-shift slices plus guard bit.
// Sticky tracking is built only when ALNSFT_STICKY_EN is defined.
module alnsft_lane
    import fma_pkg::*;
#(
    parameter int W      = ALN_W,
    parameter int SW     = ALN_SW,
    parameter int STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [STAGES-1:0] stage_ld,
    input  logic              lane_en,
    input  logic [W-1:0]      acc,
    input  logic [SW-1:0]     sft,
    output logic [W:0]        aln,
    output logic              sticky
);

    localparam int G  = ceil_div(SW, STAGES);
    localparam int PW = G * STAGES;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // shift bits not yet consumed when entering this stage
        localparam int RW = PW - k * G;

        logic [W:0]    src_dat_s;
        logic [RW-1:0] src_rem_s;
        logic          src_en_s;
        logic [PW-1:0] amt_s;
        logic [W:0]    dat_d, dat_q;
        logic          en_d, en_q;

        if (k == 0) begin : g_head
            assign src_dat_s = {acc, 1'b0};
            assign src_rem_s = RW'(sft);
            assign src_en_s  = lane_en;
        end else begin : g_tail
            assign src_dat_s = g_stage[k-1].dat_q;
            assign src_rem_s = g_stage[k-1].g_rem.rem_q;
            assign src_en_s  = g_stage[k-1].en_q;
        end

        assign amt_s = PW'(src_rem_s[G-1:0]) << (k * G);

        // masked lanes pass their enable along but keep their data frozen
        always_comb begin
            en_d  = en_q;
            dat_d = dat_q;
            if (stage_ld[k]) begin
                en_d = src_en_s;
                if (src_en_s) begin
                    dat_d = src_dat_s >> amt_s;
                end else begin
                    dat_d = dat_q;
                end
            end else begin
                en_d = en_q;
            end
        end

        // data and enable registers of this stage
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                en_q  <= 1'b0;
                dat_q <= {(W+1){1'b0}};
            end else begin
                en_q  <= en_d;
                dat_q <= dat_d;
            end
        end

        if (k < STAGES - 1) begin : g_rem
            logic [RW-G-1:0] rem_d, rem_q;

            // remaining shift bits travel with the data
            always_comb begin
                rem_d = rem_q;
                if (stage_ld[k] && src_en_s) begin
                    rem_d = src_rem_s[RW-1:G];
                end else begin
                    rem_d = rem_q;
                end
            end

            // remaining-shift register
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rem_q <= {(RW-G){1'b0}};
                end else begin
                    rem_q <= rem_d;
                end
            end
        end

`ifdef ALNSFT_STICKY_EN
        logic       src_stk_s;
        logic       stk_d, stk_q;
        logic [W:0] lost_s;

        if (k == 0) begin : g_stk_head
            assign src_stk_s = 1'b0;
        end else begin : g_stk_tail
            assign src_stk_s = g_stage[k-1].stk_q;
        end

        assign lost_s = src_dat_s & ~({(W+1){1'b1}} << amt_s);

        // partial sticky accumulates the bits dropped by each slice
        always_comb begin
            stk_d = stk_q;
            if (stage_ld[k] && src_en_s) begin
                stk_d = src_stk_s | (|lost_s);
            end else begin
                stk_d = stk_q;
            end
        end

        // sticky register of this stage
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                stk_q <= 1'b0;
            end else begin
                stk_q <= stk_d;
            end
        end
`endif
    end

    assign aln = g_stage[STAGES-1].en_q ? g_stage[STAGES-1].dat_q : {(W+1){1'b0}};

`ifdef ALNSFT_STICKY_EN
    assign sticky = g_stage[STAGES-1].en_q & g_stage[STAGES-1].stk_q;
`else
    assign sticky = 1'b0;
`endif

endmodule

// File: rtl/alnsft_pipe.sv
// Pipelined LANES-wide alignment shifter with valid/ready flow control.
// Optional sticky output enabled by ALNSFT_STICKY_EN.
module alnsft_pipe
    import fma_pkg::*;
#(
    parameter int LANES  = ALN_LANES,
    parameter int W      = ALN_W,
    parameter int SW     = ALN_SW,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES-1:0]       lane_en,
    input  logic [LANES*W-1:0]     acc,
    input  logic [LANES*SW-1:0]    sft,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*(W+1)-1:0] aln,
    output logic [LANES-1:0]       sticky
);

    logic [STAGES-1:0] v_d, v_q;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] ld_s;

    // advance ripples back from the output so a full pipe can pop and push together
    always_comb begin
        logic            carry;
        logic [STAGES:0] vin;
        carry = out_ready;
        vin   = {v_q, in_valid};
        adv_s = {STAGES{1'b0}};
        ld_s  = {STAGES{1'b0}};
        v_d   = v_q;
        for (int k = STAGES - 1; k >= 0; k--) begin
            carry    = ~v_q[k] | carry;
            adv_s[k] = carry;
        end
        for (int k = 0; k < STAGES; k++) begin
            ld_s[k] = adv_s[k] & vin[k];
            v_d[k]  = adv_s[k] ? vin[k] : v_q[k];
        end
    end

    // stage valid bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= {STAGES{1'b0}};
        end else begin
            v_q <= v_d;
        end
    end

    assign in_ready  = adv_s[0];
    assign out_valid = v_q[STAGES-1];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        alnsft_lane #(
            .W      (W),
            .SW     (SW),
            .STAGES (STAGES)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .stage_ld (ld_s),
            .lane_en  (lane_en[i]),
            .acc      (acc[i*W +: W]),
            .sft      (sft[i*SW +: SW]),
            .aln      (aln[i*(W+1) +: W+1]),
            .sticky   (sticky[i])
        );
    end

endmodule

// File: tb/tb_alnsft_pipe.sv
// Randomised and directed bench for alnsft_pipe against an arithmetic reference model.
module tb_alnsft_pipe;

    localparam int LANES  = 4;
    localparam int W      = 48;
    localparam int SW     = 6;
    localparam int STAGES = 2;
`ifdef ALNSFT_STICKY_EN
    localparam bit STK_ON = 1'b1;
`else
    localparam bit STK_ON = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES-1:0]       lane_en;
    logic [LANES*W-1:0]     acc;
    logic [LANES*SW-1:0]    sft;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*(W+1)-1:0] aln;
    logic [LANES-1:0]       sticky;

    alnsft_pipe #(.LANES(LANES), .W(W), .SW(SW), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lane_en   (lane_en),
        .acc       (acc),
        .sft       (sft),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aln       (aln),
        .sticky    (sticky)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LANES*(W+1)-1:0] aln;
        logic [LANES-1:0]       stk;
    } exp_t;

    typedef struct {
        int          lane;
        bit          en;
        logic [47:0] a;
        logic [5:0]  s;
        logic [48:0] ea;
        bit          es;
    } dir_t;

    exp_t                   q[$];
    int                     n_cmp    = 0;
    int                     n_err    = 0;
    int                     push_cnt = 0;
    int                     pop_cnt  = 0;
    bit                     hold_v   = 1'b0;
    logic [LANES*(W+1)-1:0] hold_aln;
    logic [LANES-1:0]       hold_stk;

    // Reference: each lane is ({acc,0} / 2**sft) with everything below bit 0 ORed into sticky.
    function automatic exp_t model(input logic [LANES-1:0] en, input logic [LANES*W-1:0] a,
                                   input logic [LANES*SW-1:0] s);
        exp_t        e;
        logic [63:0] full, mask, sh;
        int          amt;
        e.aln = '0;
        e.stk = '0;
        for (int i = 0; i < LANES; i++) begin
            full = {15'd0, a[i*W +: W], 1'b0};
            amt  = int'(s[i*SW +: SW]);
            if (amt >= W + 1) begin
                sh   = 64'd0;
                mask = {64{1'b1}};
            end else begin
                sh   = full >> amt;
                mask = (64'd1 << amt) - 64'd1;
            end
            if (en[i]) begin
                e.aln[i*(W+1) +: W+1] = sh[W:0];
                e.stk[i]              = STK_ON & (|(full & mask));
            end
        end
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on output transfer, check hold stability.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                n_cmp++;
                if (!out_valid || aln !== hold_aln || sticky !== hold_stk) begin
                    n_err++;
                    $display("FAIL stall_stable: valid=%b aln=%h sticky=%b, required valid=1 aln=%h sticky=%b",
                             out_valid, aln, sticky, hold_aln, hold_stk);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra: output transfer with no outstanding request, aln=%h", aln);
                end else begin
                    e = q.pop_front();
                    if (aln !== e.aln || sticky !== e.stk) begin
                        n_err++;
                        $display("FAIL sb_data: aln=%h sticky=%b, required aln=%h sticky=%b",
                                 aln, sticky, e.aln, e.stk);
                    end
                end
                pop_cnt++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(lane_en, acc, sft));
                push_cnt++;
            end
            hold_v   = out_valid && !out_ready;
            hold_aln = aln;
            hold_stk = sticky;
        end
    end

    task automatic rand_req();
        lane_en = 4'($urandom);
        acc     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        sft     = 24'($urandom);
    endtask

    // Starts and ends at posedge+1; holds in_valid until the accept edge.
    task automatic send();
        int b;
        in_valid = 1'b1;
        b = 0;
        @(negedge clk);
        while (!in_ready && b < 40) begin
            @(negedge clk);
            b++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_accept: in_ready=%b, required 1 within 40 cycles", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        b = 0;
        while ((q.size() != 0 || out_valid) && b < 20) begin
            @(posedge clk);
            #1;
            b++;
        end
        n_cmp++;
        if (q.size() != 0 || out_valid) begin
            n_err++;
            $display("FAIL drain: outstanding=%0d out_valid=%b, required 0 and 0", q.size(), out_valid);
        end
    endtask

    task automatic test_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        lane_en   = '0;
        acc       = '0;
        sft       = '0;
        reset     = 1'b1;
        #2 reset  = 1'b0;
        #2;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: out_valid=%b required 0", out_valid);
        end
        if (aln !== '0) begin
            n_err++;
            $display("FAIL reset_aln: aln=%h required 0", aln);
        end
        if (sticky !== '0) begin
            n_err++;
            $display("FAIL reset_sticky: sticky=%b required 0", sticky);
        end
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_in_ready: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        dir_t                   tbl[6];
        logic [LANES*(W+1)-1:0] ea;
        logic [LANES-1:0]       es;
        tbl[0] = '{0, 1'b1, 48'h8000_0000_0000, 6'd0,  49'h1_0000_0000_0000, 1'b0};
        tbl[1] = '{1, 1'b1, 48'h0000_0000_0001, 6'd1,  49'h0_0000_0000_0001, 1'b0};
        tbl[2] = '{1, 1'b1, 48'h0000_0000_0001, 6'd2,  49'h0_0000_0000_0000, STK_ON};
        tbl[3] = '{2, 1'b1, 48'hFFFF_FFFF_FFFF, 6'd63, 49'h0_0000_0000_0000, STK_ON};
        tbl[4] = '{2, 1'b1, 48'h0000_0000_0000, 6'd63, 49'h0_0000_0000_0000, 1'b0};
        tbl[5] = '{3, 1'b0, 48'hFFFF_FFFF_FFFF, 6'd5,  49'h0_0000_0000_0000, 1'b0};
        out_ready = 1'b1;
        for (int t = 0; t < 6; t++) begin
            rand_req();
            lane_en                     = tbl[t].en ? (4'd1 << tbl[t].lane) : 4'd0;
            acc[tbl[t].lane*W +: W]     = tbl[t].a;
            sft[tbl[t].lane*SW +: SW]   = tbl[t].s;
            ea                          = '0;
            ea[tbl[t].lane*(W+1) +: W+1] = tbl[t].ea;
            es                          = 4'(tbl[t].es) << tbl[t].lane;
            send();
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL dir%0d_early: out_valid=%b one cycle after accept, required 0", t, out_valid);
            end
            @(negedge clk);
            n_cmp += 3;
            if (out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL dir%0d_latency: out_valid=%b two cycles after accept, required 1", t, out_valid);
            end
            if (aln !== ea) begin
                n_err++;
                $display("FAIL dir%0d_aln: aln=%h required %h", t, aln, ea);
            end
            if (sticky !== es) begin
                n_err++;
                $display("FAIL dir%0d_sticky: sticky=%b required %b", t, sticky, es);
            end
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rand_req();
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int  base, seen, pbase;
        bit  allv;
        out_ready = 1'b0;
        base      = push_cnt;
        seen      = push_cnt;
        rand_req();
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (push_cnt != seen) begin
                seen = push_cnt;
                rand_req();
            end
        end
        n_cmp++;
        if (push_cnt - base != 2) begin
            n_err++;
            $display("FAIL bp_accepts: accepted %0d while stalled, required 2", push_cnt - base);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp_in_ready: in_ready=%b with full pipe, required 0", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        pbase     = pop_cnt;
        allv      = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (!out_valid) allv = 1'b0;
            @(posedge clk);
            #1;
            if (push_cnt - base >= 6) begin
                in_valid = 1'b0;
            end else if (push_cnt != seen) begin
                seen = push_cnt;
                rand_req();
            end
        end
        n_cmp += 2;
        if (!allv) begin
            n_err++;
            $display("FAIL bp_rate: out_valid dropped during release, required 1 every cycle");
        end
        if (pop_cnt - pbase != 6) begin
            n_err++;
            $display("FAIL bp_pops: popped %0d, required 6", pop_cnt - pbase);
        end
        drain();
    endtask

    task automatic test_full_pop_push();
        int p0, q0;
        out_ready = 1'b0;
        rand_req();
        send();
        rand_req();
        send();
        rand_req();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        p0 = push_cnt;
        q0 = pop_cnt;
        @(negedge clk);
        n_cmp += 2;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL pp_in_ready: in_ready=%b with full pipe and out_ready=1, required 1", in_ready);
        end
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL pp_out_valid: out_valid=%b, required 1", out_valid);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++;
        if (push_cnt != p0 + 1 || pop_cnt != q0 + 1) begin
            n_err++;
            $display("FAIL pp_counts: pushes=%0d pops=%0d, required 1 and 1", push_cnt - p0, pop_cnt - q0);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL pp_still_full: out_valid=%b in_ready=%b, required 1 and 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        rand_req();
        lane_en = 4'hF;
        send();
        rand_req();
        lane_en = 4'hF;
        send();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rm_inflight: out_valid=%b before reset, required 1", out_valid);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp += 3;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rm_valid: out_valid=%b during reset, required 0", out_valid);
        end
        if (aln !== '0) begin
            n_err++;
            $display("FAIL rm_aln: aln=%h during reset, required 0", aln);
        end
        if (sticky !== '0) begin
            n_err++;
            $display("FAIL rm_sticky: sticky=%b during reset, required 0", sticky);
        end
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rm_after: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        rand_req();
        lane_en = 4'hF;
        send();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rm_early: out_valid=%b one cycle after accept, required 0", out_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rm_latency: out_valid=%b two cycles after accept, required 1", out_valid);
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_full_pop_push();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
